// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: Moore sequencer over the shared datapath.
// Memory-facing enables are qualified by mem_ready; all writes are gated by rst.
module mips_multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               ExtOp,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IEXEC    = 4'd9,
        S_IWB      = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       op_legal;
    logic       ir_write, pc_write, branch, mem_write, reg_write;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        op_legal = 1'b1;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = Op;
                case (Op)
                    OP_LW, OP_SW:            state_d = S_MEMADR;
                    OP_R:                    state_d = S_EXECUTE;
                    OP_BEQ:                  state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
                    OP_J:                    state_d = S_JUMP;
                    default: begin
                        state_d  = S_FETCH;
                        op_legal = 1'b0;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            S_IEXEC:    state_d = S_IWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        IorD      = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        reg_write = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 3'b000;
        PCSrc     = 2'b00;
        pc_write  = 1'b0;
        branch    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                IorD      = 1'b1;
                mem_write = mem_ready;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b001;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (op_q == OP_ANDI)     ALUOp = 3'b011;
                else if (op_q == OP_ORI) ALUOp = 3'b100;
            end
            S_IWB:      reg_write = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch offsets are extended during DECODE, before op_q is loaded
    always_comb begin
        if (state_q == S_DECODE)
            ExtOp = !(Op == OP_ANDI || Op == OP_ORI);
        else
            ExtOp = !(op_q == OP_ANDI || op_q == OP_ORI);
    end

    assign IRWrite    = ir_write & ~rst;
    assign MemWrite   = mem_write & ~rst;
    assign RegWrite   = reg_write & ~rst;
    assign PCEn       = (pc_write | (branch & Zero)) & ~rst;
    assign illegal_op = (state_q == S_DECODE) & ~op_legal & ~rst;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: stimulus pushes per-cycle expected control words,
// a negedge monitor pops and compares them against the DUT.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, ExtOp, PCEn, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Zero(Zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ExtOp(ExtOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .illegal_op(illegal_op), .state(state)
    );

    typedef struct {
        logic [20:0] exp;
        string       name;
        int          cyc;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    st_q[$];
    int    mr_q[$];
    int    rs_q[$];
    logic [5:0] opq_m = 6'b0;

    // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,
    //  ALUOp,ExtOp,PCSrc,PCEn,illegal_op,state}
    function automatic logic [20:0] expv(int s, logic [5:0] op,
                                         logic [5:0] opq, logic mr,
                                         logic z, logic r);
        logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0;
        logic sa = 0, pcw = 0, br = 0, ill = 0, ext;
        logic [1:0] sbx = 2'b00, pcs = 2'b00;
        logic [2:0] aop = 3'b000;
        bit legal;
        legal = (op == 6'b000000) || (op == 6'b100011) ||
                (op == 6'b101011) || (op == 6'b000100) ||
                (op == 6'b001000) || (op == 6'b001100) ||
                (op == 6'b001101) || (op == 6'b000010);
        case (s)
            0: begin sbx = 2'b01; irw = mr; pcw = mr; end
            1: begin sbx = 2'b11; ill = !legal; end
            2: begin sa = 1; sbx = 2'b10; end
            3: iord = 1;
            4: begin m2r = 1; rw = 1; end
            5: begin iord = 1; mw = mr; end
            6: begin sa = 1; aop = 3'b010; end
            7: begin rd = 1; rw = 1; end
            8: begin sa = 1; aop = 3'b001; pcs = 2'b01; br = 1; end
            9: begin
                sa = 1; sbx = 2'b10;
                aop = (opq == 6'b001100) ? 3'b011 :
                      (opq == 6'b001101) ? 3'b100 : 3'b000;
            end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (s == 1) ext = !(op == 6'b001100 || op == 6'b001101);
        else        ext = !(opq == 6'b001100 || opq == 6'b001101);
        if (r) begin irw = 0; mw = 0; rw = 0; ill = 0; pcw = 0; br = 0; end
        return {iord, mw, irw, rd, m2r, rw, sa, sbx, aop, ext, pcs,
                pcw | (br & z), ill, 4'(s)};
    endfunction

    task automatic run(input string name, input logic [5:0] op,
                       input logic z);
        for (int i = 0; i < st_q.size(); i++) begin
            item_t it;
            logic r;
            r = (rs_q.size() > i) ? rs_q[i][0] : 1'b0;
            @(posedge clk);
            #1;
            rst = r;
            Op = op;
            Zero = z;
            mem_ready = mr_q[i][0];
            it.exp = expv(st_q[i], op, opq_m, mr_q[i][0], z, r);
            it.name = name;
            it.cyc = i;
            sb.push_back(it);
            if (r) opq_m = 6'b0;
            else if (st_q[i] == 1) opq_m = op;
        end
        st_q.delete();
        mr_q.delete();
        rs_q.delete();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            logic [20:0] got;
            it = sb.pop_front();
            got = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSrc, PCEn,
                   illegal_op, state};
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h required %h",
                         it.name, it.cyc, got, it.exp);
            end
        end
    end

    initial begin
        st_q = '{0, 0}; mr_q = '{1, 1}; rs_q = '{1, 1};
        run("reset", 6'b000000, 1'b0);

        st_q = '{0, 1, 6, 7}; mr_q = '{1, 1, 1, 1};
        run("rtype", 6'b000000, 1'b0);

        st_q = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        mr_q = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        run("lw_stall", 6'b100011, 1'b0);

        st_q = '{0, 1, 2, 5, 5, 0, 0, 1, 2, 5};
        mr_q = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        rs_q = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        run("sw_reset", 6'b101011, 1'b0);

        st_q = '{0, 1, 8}; mr_q = '{1, 1, 1};
        run("beq_z1", 6'b000100, 1'b1);
        st_q = '{0, 1, 8}; mr_q = '{1, 1, 1};
        run("beq_z0", 6'b000100, 1'b0);

        st_q = '{0, 1, 9, 10}; mr_q = '{1, 1, 1, 1};
        run("andi", 6'b001100, 1'b0);
        st_q = '{0, 1, 9, 10}; mr_q = '{1, 1, 1, 1};
        run("ori", 6'b001101, 1'b0);
        st_q = '{0, 1, 9, 10}; mr_q = '{1, 1, 1, 1};
        run("addi", 6'b001000, 1'b0);

        st_q = '{0, 1}; mr_q = '{1, 1};
        run("illegal", 6'b111111, 1'b0);
        st_q = '{0, 1, 11}; mr_q = '{1, 1, 1};
        run("jump", 6'b000010, 1'b0);
        st_q = '{0}; mr_q = '{0};
        run("after_j", 6'b000010, 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
